seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//  Time-multiplexed driver for an NDIG-digit seven-segment display. Holds a packed hex value,
//  steps one digit per prescaler tick and presents that digit's nibble plus enable to the
//  downstream 4-bit hex-to-segment decoder (x/en -> HEX0), together with an active-low digit select.
//  New values are double-buffered and take effect only at frame boundaries, so a frame never tears.
// PARAMETERS
//  NDIG     8      number of digits scanned; >=2; IW = clog2(NDIG)
//  CLK_DIV  50000  clk cycles per digit slot; >=1 (1 = advance every cycle)
// PORTS
//  clk       in   1        system clock, rising edge
//  rst_n     in   1        asynchronous reset, active low
//  value     in   4*NDIG   hex value; digit i = value[4i+3:4i], digit 0 = least significant
//  load      in   1        1-cycle strobe: capture value into shadow register
//  digit_en  in   NDIG     per-digit enable mask; 0 forces that digit blank
//  x         out  4        nibble of current digit -> decoder x
//  en        out  1        current digit visible -> decoder en (0 = decoder blanks)
//  an        out  NDIG     digit select, active low, one-hot-zero of current digit
//  frame     out  1        1-cycle pulse when digit index wraps NDIG-1 -> 0
// BEHAVIOUR
//  Reset (async on rst_n=0, released sync): div=0, idx=0, disp=0, shadow=0, pending=0,
//   x=0, en=0, an=all ones, frame=0. Reset mid-frame abandons the frame and any pending load.
//  Prescaler: div counts 0..CLK_DIV-1, wraps to 0; tick = (div==CLK_DIV-1).
//  Digit index: on tick idx <= (idx==NDIG-1) ? 0 : idx+1; wrap asserts frame for that same cycle.
//  Load: load=1 -> shadow<=value, pending<=1. Repeated loads before commit: last one wins.
//  Commit: on the wrap tick, if pending: disp<=shadow, pending<=0.
//   load and wrap tick in same cycle: old shadow committed to disp, new value captured, pending stays 1.
//  Outputs registered; they reflect idx and disp one cycle after idx/disp change:
//   x <= disp[4*idx+:4]; an <= ~(1<<idx); en <= digit_en[idx] & ~blank(idx).
//  Without LZB: blank(i)=0. Value 0 with all digit_en=1 shows all zeros.
//  digit_en changes take effect on the next output register update (no frame buffering).
//  First digit after reset: an=~1 from the first post-reset cycle onward; en=digit_en[0].
// CONFIGURATION
//  SEG_SCAN_LZB_EN defined: leading-zero blanking. blank(i)=1 for every i>0 where all of
//   disp digits i..NDIG-1 are 0; digit 0 never blanked. Computed from disp (committed value).
//  SEG_SCAN_LZB_EN undefined: blank logic absent, blank(i)=0 for all i.
// TESTING  (bench: NDIG=4, CLK_DIV=4)
//  Reset: hold rst_n=0 5 cycles mid-scan -> an=4'b1111, en=0, x=0, frame=0 immediately (async).
//  Scan: load 16'h1234, digit_en=4'hF -> after commit frame, an sequence 1110,1101,1011,0111
//   each held exactly 4 cycles, x = 4,3,2,1 in lockstep, frame pulses once per 16 cycles.
//  No tearing: load 16'hABCD then 16'h5678 mid-frame -> current frame keeps old digits;
//   next frame shows 8,7,6,5; ABCD never displayed.
//  Load on wrap tick: load 16'h0F0F exactly on frame cycle -> prior shadow shown this frame,
//   0F0F shown from the following frame.
//  Mask: digit_en=4'b0101 with 16'h1234 -> en=1 on digits 0,2 only; an still scans all four.
//  LZB (SEG_SCAN_LZB_EN): 16'h0030 -> en=1 digits 0,1 only; 16'h0000 -> only digit 0 shown (x=0);
//   without macro 16'h0030 -> all four en=1.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with frame-synchronous double-buffered value.
// Optional leading-zero blanking is compiled in when SEG_SCAN_LZB_EN is defined.
module seg_scan_ctrl #(
    parameter int NDIG    = 8,
    parameter int CLK_DIV = 50000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*NDIG-1:0]   value,
    input  logic                load,
    input  logic [NDIG-1:0]     digit_en,
    output logic [3:0]          x,
    output logic                en,
    output logic [NDIG-1:0]     an,
    output logic                frame
);

    localparam int IW = $clog2(NDIG);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NDIG - 1);

    logic [DW-1:0]      div_q, div_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [4*NDIG-1:0]  disp_q, disp_d;
    logic [4*NDIG-1:0]  shadow_q, shadow_d;
    logic               pending_q, pending_d;
    logic [3:0]         x_q, x_d;
    logic               en_q, en_d;
    logic [NDIG-1:0]    an_q, an_d;
    logic [NDIG-1:0]    blank;
    logic               tick;
    logic               wrap;

    assign tick = (div_q == DIV_LAST);
    assign wrap = tick && (idx_q == IDX_LAST);

    genvar gi;

`ifdef SEG_SCAN_LZB_EN
    // upper_zero[i]: committed digits i..NDIG-1 are all zero; digit 0 is never blanked
    logic [NDIG-1:1] upper_zero;
    assign upper_zero[NDIG-1] = (disp_q[4*(NDIG-1) +: 4] == 4'h0);
    generate
        for (gi = 1; gi < NDIG-1; gi++) begin : g_lzb
            assign upper_zero[gi] = (disp_q[4*gi +: 4] == 4'h0) && upper_zero[gi+1];
        end
    endgenerate
    assign blank = {upper_zero, 1'b0};
`else
    assign blank = '0;
`endif

    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_an
            assign an_d[gi] = (idx_q != IW'(gi));
        end
    endgenerate

    always_comb begin
        div_d     = tick ? '0 : div_q + 1'b1;
        idx_d     = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
        shadow_d  = load ? value : shadow_q;
        // Commit uses the shadow as it stood before this cycle's load, so a
        // load coinciding with the wrap stays pending for the following frame.
        disp_d    = (wrap && pending_q) ? shadow_q : disp_q;
        pending_d = load || (pending_q && !wrap);
        x_d       = disp_q[4*idx_q +: 4];
        en_d      = digit_en[idx_q] && !blank[idx_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            idx_q     <= '0;
            disp_q    <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
            x_q       <= 4'h0;
            en_q      <= 1'b0;
            an_q      <= '1;
        end else begin
            div_q     <= div_d;
            idx_q     <= idx_d;
            disp_q    <= disp_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            x_q       <= x_d;
            en_q      <= en_d;
            an_q      <= an_d;
        end
    end

    assign x     = x_q;
    assign en    = en_q;
    assign an    = an_q;
    assign frame = wrap;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl (NDIG=4, CLK_DIV=4): per-frame vector table plus reset sequences.
module tb_seg_scan_ctrl;

    localparam int NDIG    = 4;
    localparam int CLK_DIV = 4;
`ifdef SEG_SCAN_LZB_EN
    localparam logic LZB = 1'b1;
`else
    localparam logic LZB = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] value = 16'h0000;
    logic        load = 1'b0;
    logic [3:0]  digit_en = 4'hF;
    logic [3:0]  x;
    logic        en;
    logic [3:0]  an;
    logic        frame;

    int n_checks = 0;
    int n_errors = 0;

    seg_scan_ctrl #(.NDIG(NDIG), .CLK_DIV(CLK_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .value    (value),
        .load     (load),
        .digit_en (digit_en),
        .x        (x),
        .en       (en),
        .an       (an),
        .frame    (frame)
    );

    always #5 clk = ~clk;

    // One record per displayed frame; ld_j / ld2_j are slot indices (-1 = none)
    typedef struct {
        string       name;
        logic        wrap_ld;
        logic [15:0] wrap_val;
        logic [3:0]  dig_en;
        int          ld_j;
        logic [15:0] ld_val;
        int          ld2_j;
        logic [15:0] ld2_val;
        logic [15:0] exp_disp;
        logic [3:0]  exp_en;
    } frame_vec_t;

    frame_vec_t vecs[8];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".an"},    {12'h0, an},    16'h000F);
        chk({tag, ".en"},    {15'h0, en},    16'h0000);
        chk({tag, ".x"},     {12'h0, x},     16'h0000);
        chk({tag, ".frame"}, {15'h0, frame}, 16'h0000);
    endtask

    // Starts on the negedge right after reset release; ends on the first frame cycle.
    task automatic post_reset(input string tag, input int ld_k, input logic [15:0] ld_val,
                              input logic [3:0] zero_en);
        logic [3:0] one;
        logic [3:0] exp_an;
        int d;
        one = 4'b0001;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            load = 1'b0;
            d = (k - 1) / 4;
            exp_an = ~(one << d);
            chk({tag, ".an"},    {12'h0, an},    {12'h0, exp_an});
            chk({tag, ".x"},     {12'h0, x},     16'h0000);
            chk({tag, ".en"},    {15'h0, en},    {15'h0, zero_en[d]});
            chk({tag, ".frame"}, {15'h0, frame}, (k == 15) ? 16'h0001 : 16'h0000);
            if (k == ld_k) begin
                load  = 1'b1;
                value = ld_val;
            end
        end
    endtask

    // Entered on a frame cycle; checks slots 0..14 of the next frame and ends on its frame cycle.
    task automatic run_frame(input string tag, input logic [15:0] exp_disp, input logic [3:0] exp_en,
                             input int ld_j, input logic [15:0] ld_val,
                             input int ld2_j, input logic [15:0] ld2_val);
        logic [3:0] one;
        logic [3:0] exp_an;
        int d;
        one = 4'b0001;
        @(negedge clk);
        load = 1'b0;
        for (int j = 0; j < 15; j++) begin
            @(negedge clk);
            load = 1'b0;
            d = j / 4;
            exp_an = ~(one << d);
            chk({tag, ".an"},    {12'h0, an},    {12'h0, exp_an});
            chk({tag, ".x"},     {12'h0, x},     {12'h0, exp_disp[4*d +: 4]});
            chk({tag, ".en"},    {15'h0, en},    {15'h0, exp_en[d]});
            chk({tag, ".frame"}, {15'h0, frame}, (j == 14) ? 16'h0001 : 16'h0000);
            if (j == ld_j) begin
                load  = 1'b1;
                value = ld_val;
            end
            if (j == ld2_j) begin
                load  = 1'b1;
                value = ld2_val;
            end
        end
    endtask

    initial begin
        logic [3:0] zero_en;
        zero_en = LZB ? 4'b0001 : 4'b1111;

        vecs[0] = '{"scan",      1'b0, 16'h0000, 4'hF,    -1, 16'h0000, -1, 16'h0000, 16'h1234, 4'hF};
        vecs[1] = '{"tear_old",  1'b0, 16'h0000, 4'hF,     3, 16'hABCD,  8, 16'h5678, 16'h1234, 4'hF};
        vecs[2] = '{"tear_new",  1'b0, 16'h0000, 4'hF,     5, 16'h1234, -1, 16'h0000, 16'h5678, 4'hF};
        vecs[3] = '{"wrap_old",  1'b1, 16'h0F0F, 4'hF,    -1, 16'h0000, -1, 16'h0000, 16'h1234, 4'hF};
        vecs[4] = '{"wrap_new",  1'b0, 16'h0000, 4'hF,     2, 16'h1234, -1, 16'h0000, 16'h0F0F,
                    LZB ? 4'b0111 : 4'b1111};
        vecs[5] = '{"mask",      1'b0, 16'h0000, 4'b0101,  1, 16'h0030, -1, 16'h0000, 16'h1234, 4'b0101};
        vecs[6] = '{"val_0030",  1'b0, 16'h0000, 4'hF,     1, 16'h0000, -1, 16'h0000, 16'h0030,
                    LZB ? 4'b0011 : 4'b1111};
        vecs[7] = '{"val_0000",  1'b0, 16'h0000, 4'hF,    -1, 16'h0000, -1, 16'h0000, 16'h0000, zero_en};

        // Power-on reset, asserted asynchronously away from any clock edge
        #2 rst_n = 1'b0;
        #1 chk_reset("por_async");
        repeat (5) begin
            @(negedge clk);
            chk_reset("por_hold");
        end
        rst_n = 1'b1;
        post_reset("startup", 2, 16'h1234, zero_en);
        $display("startup: first scan after reset, load 1234 queued, errors=%0d", n_errors);

        for (int i = 0; i < 8; i++) begin
            digit_en = vecs[i].dig_en;
            if (vecs[i].wrap_ld) begin
                load  = 1'b1;
                value = vecs[i].wrap_val;
            end
            run_frame(vecs[i].name, vecs[i].exp_disp, vecs[i].exp_en,
                      vecs[i].ld_j, vecs[i].ld_val, vecs[i].ld2_j, vecs[i].ld2_val);
            $display("frame %0d %s: disp=%h en_mask=%b errors=%0d",
                     i, vecs[i].name, vecs[i].exp_disp, vecs[i].exp_en, n_errors);
        end

        // Mid-scan reset with a load still pending: both must be abandoned
        repeat (3) @(negedge clk);
        load  = 1'b1;
        value = 16'h9999;
        @(negedge clk);
        load = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1 chk_reset("mid_async");
        repeat (5) begin
            @(negedge clk);
            chk_reset("mid_hold");
        end
        rst_n = 1'b1;
        post_reset("mid_restart", -1, 16'h0000, zero_en);
        run_frame("mid_no_commit", 16'h0000, zero_en, -1, 16'h0000, -1, 16'h0000);
        $display("mid-scan reset: pending 9999 dropped, errors=%0d", n_errors);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
